// File: rtl/execute_unit.sv
// ============================================================================
// Module   : execute_unit
// Purpose  : Execute stage. Single-cycle ALU plus a 32-iteration shift-add
//            multiplier that drives the register file write port.
//            Optional macro EXEC_MULH_EN adds opcode 9 (MULH, upper product).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module execute_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MUL_CYCLES = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [ADDR_WIDTH-1:0] dest_address,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic                  write_enable,
    output logic                  zero,
    output logic                  illegal_op
);

`ifdef EXEC_MULH_EN
    localparam int ACC_W = 2 * DATA_WIDTH;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

    localparam logic [0:0] c_S_IDLE    = 1'b0;
    localparam logic [0:0] c_S_MUL_RUN = 1'b1;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SLT  = 4'd7;
    localparam logic [3:0] c_OP_MUL  = 4'd8;
    localparam logic [3:0] c_OP_MULH = 4'd9;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [ACC_W-1:0]      r_mcand;
    logic [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_dest;
    logic [DATA_WIDTH-1:0] r_result;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_we;
    logic                  r_zero;
    logic                  r_illegal;
`ifdef EXEC_MULH_EN
    logic                  r_mulh;
`endif

    logic                  w_idle_start;
    logic                  w_is_alu;
    logic                  w_is_mul;
    logic                  w_mul_done;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [ACC_W-1:0]      w_acc_sum;
    logic [DATA_WIDTH-1:0] w_mul_result;

    assign w_idle_start = start && (r_state == c_S_IDLE);
    assign w_is_alu     = (opcode < c_OP_MUL);
`ifdef EXEC_MULH_EN
    assign w_is_mul     = (opcode == c_OP_MUL) || (opcode == c_OP_MULH);
`else
    assign w_is_mul     = (opcode == c_OP_MUL);
`endif
    assign w_mul_done   = (r_state == c_S_MUL_RUN) && (r_count == CNT_W'(MUL_CYCLES - 1));

    // Final iteration's partial product is folded in combinationally so the
    // write lands on the same edge the counter reaches MUL_CYCLES.
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
`ifdef EXEC_MULH_EN
    assign w_mul_result = r_mulh ? w_acc_sum[ACC_W-1 -: DATA_WIDTH] : w_acc_sum[DATA_WIDTH-1:0];
`else
    assign w_mul_result = w_acc_sum;
`endif

    always_comb begin
        w_alu = '0;
        case (opcode)
            c_OP_ADD: w_alu = operand_a + operand_b;
            c_OP_SUB: w_alu = operand_a - operand_b;
            c_OP_AND: w_alu = operand_a & operand_b;
            c_OP_OR:  w_alu = operand_a | operand_b;
            c_OP_XOR: w_alu = operand_a ^ operand_b;
            c_OP_SLL: w_alu = operand_a << operand_b[4:0];
            c_OP_SRL: w_alu = operand_a >> operand_b[4:0];
            c_OP_SLT: w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:    if (start && w_is_mul) w_state_next = c_S_MUL_RUN;
            c_S_MUL_RUN: if (w_mul_done)        w_state_next = c_S_IDLE;
            default:                            w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_S_MUL_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_dest    <= '0;
            r_result  <= '0;
            r_waddr   <= '0;
            r_we      <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef EXEC_MULH_EN
            r_mulh    <= 1'b0;
`endif
        end else begin
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            if (w_idle_start) begin
                if (w_is_alu) begin
                    r_result <= w_alu;
                    r_waddr  <= dest_address;
                    r_zero   <= (w_alu == '0);
                    r_we     <= 1'b1;
                end else if (w_is_mul) begin
                    r_mcand  <= ACC_W'(operand_a);
                    r_mplier <= operand_b;
                    r_acc    <= '0;
                    r_count  <= '0;
                    r_dest   <= dest_address;
`ifdef EXEC_MULH_EN
                    r_mulh   <= (opcode == c_OP_MULH);
`endif
                end else begin
                    r_illegal <= 1'b1;
                end
            end else if (r_state == c_S_MUL_RUN) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
                if (w_mul_done) begin
                    r_result <= w_mul_result;
                    r_waddr  <= r_dest;
                    r_zero   <= (w_mul_result == '0);
                    r_we     <= 1'b1;
                end
            end
        end
    end

    assign result        = r_result;
    assign write_address = r_waddr;
    assign write_enable  = r_we;
    assign zero          = r_zero;
    assign illegal_op    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_execute_unit.sv
// ============================================================================
// Module   : tb_execute_unit
// Purpose  : Scoreboard bench for execute_unit; directed vectors, queued
//            expectations popped by a write-port monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_execute_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_address;
    logic        busy;
    logic [31:0] result;
    logic [4:0]  write_address;
    logic        write_enable;
    logic        zero;
    logic        illegal_op;

    execute_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .MUL_CYCLES (32)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .dest_address  (dest_address),
        .busy          (busy),
        .result        (result),
        .write_address (write_address),
        .write_enable  (write_enable),
        .zero          (zero),
        .illegal_op    (illegal_op)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  addr;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_pass        = 0;
    int   n_total       = 0;
    int   n_illegal     = 0;
    int   exp_illegal   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        start        = 1'b1;
        opcode       = op;
        operand_a    = a;
        operand_b    = b;
        dest_address = d;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] a);
        exp_t e;
        e.res  = r;
        e.addr = a;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Write-port monitor: every write must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (write_enable) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got result %h addr %0d expected no write",
                             result, write_address);
                end else begin
                    m_e = sb.pop_front();
                    chk("wr_result", result, m_e.res);
                    chk("wr_addr", {27'b0, write_address}, {27'b0, m_e.addr});
                    chk("wr_zero", {31'b0, zero}, {31'b0, (m_e.res == 32'd0)});
                end
            end
            if (illegal_op) n_illegal++;
        end
    end

    initial begin
        int w;
        reset        = 1'b1;
        start        = 1'b0;
        opcode       = 4'd0;
        operand_a    = 32'd0;
        operand_b    = 32'd0;
        dest_address = 5'd0;
        #2;
        chk("rst_result", result, 32'd0);
        chk("rst_ctrl", {27'b0, busy, write_enable, zero, illegal_op, 1'b0}, 32'd0);
        chk("rst_waddr", {27'b0, write_address}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // ALU vectors, issued back-to-back.
        do_op(4'd0, 32'd5, 32'd7, 5'd3);                 push(32'd12, 5'd3);
        @(posedge clock); #1;
        chk("we_low_after_add", {31'b0, write_enable}, 32'd0);
        do_op(4'd1, 32'd5, 32'd5, 5'd4);                 push(32'd0, 5'd4);
        do_op(4'd1, 32'd0, 32'd1, 5'd5);                 push(32'hFFFFFFFF, 5'd5);
        do_op(4'd7, 32'hFFFFFFFF, 32'd1, 5'd6);          push(32'd1, 5'd6);
        do_op(4'd6, 32'h80000000, 32'd31, 5'd8);         push(32'd1, 5'd8);
        do_op(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd9);   push(32'h00F000F0, 5'd9);
        do_op(4'd3, 32'h0F0000F0, 32'h00F00F00, 5'd10);  push(32'h0FF00FF0, 5'd10);
        do_op(4'd4, 32'hAAAA5555, 32'hFFFF0000, 5'd11);  push(32'h55555555, 5'd11);
        do_op(4'd5, 32'd1, 32'h00000023, 5'd0);          push(32'd8, 5'd0);
        drain();

        // Illegal opcode: pulse, no write, result/address hold.
        do_op(4'd12, 32'd1, 32'd2, 5'd20);
        exp_illegal++;
        @(posedge clock); #1;
        chk("illegal_hold_result", result, 32'd8);
        chk("illegal_hold_waddr", {27'b0, write_address}, 32'd0);

        // MUL with an ignored ADD attempt during the busy window.
        do_op(4'd8, 32'h0000FFFF, 32'h00010001, 5'd7);   push(32'hFFFFFFFF, 5'd7);
        for (int k = 0; k < 32; k++) begin
            if (k == 0 || k == 31) chk("mul_busy", {31'b0, busy}, 32'd1);
            if (k == 5) begin
                start = 1'b1; opcode = 4'd0; operand_a = 32'd1; operand_b = 32'd1; dest_address = 5'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
        end
        chk("mul_done_busy", {31'b0, busy}, 32'd0);
        chk("mul_done_we", {31'b0, write_enable}, 32'd1);
        drain();

        // MUL then ADD accepted on the MUL's write cycle.
        do_op(4'd8, 32'd3, 32'd4, 5'd12);                push(32'd12, 5'd12);
        w = 0;
        while (!write_enable && w < 40) begin
            @(posedge clock); #1;
            w++;
        end
        chk("mul_latency", w, 32);
        do_op(4'd0, 32'd1, 32'd1, 5'd13);                push(32'd2, 5'd13);
        drain();

        // Asynchronous reset mid-multiply: no write may follow.
        do_op(4'd8, 32'd5, 32'd6, 5'd14);
        repeat (4) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_ctrl", {30'b0, busy, write_enable}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        do_op(4'd0, 32'd5, 32'd7, 5'd3);                 push(32'd12, 5'd3);
        drain();

        // Opcode 9.
`ifdef EXEC_MULH_EN
        do_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15);  push(32'hFFFFFFFE, 5'd15);
`else
        do_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15);
        exp_illegal++;
`endif
        drain();
        repeat (3) @(posedge clock);
        #1;
        chk("illegal_pulses", n_illegal, exp_illegal);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Execute stage directly downstream of the register file.
- Consumes the two register read operands plus a decoded opcode and destination address, then computes a result.
- Drives the register file write port: write_data_in, write_address and WriteEnable.
- Single-cycle ALU ops; a 32-iteration shift-add multiplier FSM with a busy/start handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 supported.
- ADDR_WIDTH, 5, destination register address width.
- MUL_CYCLES, 32, multiplier iterations; must equal DATA_WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request to execute; accepted only on an edge where busy=0.
- opcode  input  4  operation select, encoding below.
- operand_a  input  32  from register file data_out_1.
- operand_b  input  32  from register file data_out_2.
- dest_address  input  5  destination register.
- busy  output  1  high while the multiplier FSM runs; start is ignored.
- result  output  32  to register file write_data_in.
- write_address  output  5  to register file write_address.
- write_enable  output  1  one-cycle pulse to register file WriteEnable.
- zero  output  1  result==0, valid with write_enable.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (asynchronous): state=IDLE; busy, write_enable, illegal_op, zero =0; result=0; write_address=0; counter=0. Any in-flight multiply is discarded with no write.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: shift amount is operand_b[4:0]; logical shifts.
  - 7 SLT: signed compare, result 1 or 0.
  - 8 MUL: low 32 bits of the unsigned product.
  - 9–15: illegal, except 9 under the optional feature.
- ADD/SUB wrap modulo 2^32; no overflow flag.
- FSM states IDLE, MUL_RUN.
- IDLE, start=1, opcode 0–7 (edge N):
  - result, write_address and zero are registered at edge N.
  - write_enable=1 for the cycle after edge N only.
  - State stays IDLE, so back-to-back starts each cycle give back-to-back writes.
- IDLE, start=1, opcode 8 (edge N):
  - Latch multiplicand=operand_a, multiplier=operand_b, dest, acc=0, counter=0.
  - busy=1 from edge N; state→MUL_RUN.
- MUL_RUN, each edge:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - On the edge where counter reaches 31→32 (edge N+32): result=acc (final), write_enable pulses for one cycle, busy=0, state→IDLE.
- Multiply latency: 32 cycles from the accepting edge to the write_enable cycle.
- start while busy=1: ignored entirely; no queueing and no error flag.
- start with an illegal opcode: illegal_op pulses for one cycle; no write_enable; result and write_address hold.
- The cycle in which the multiply's write_enable is high has busy=0, so a new start is accepted on that cycle's closing edge.
- start=0: write_enable and illegal_op return to 0 on the next edge; result holds its last value.
- Inputs are sampled only at the accepting edge; they may change during MUL_RUN.
- dest_address 0 is written like any other register; there is no hardwired zero register.

Optional Feature:
- Macro EXEC_MULH_EN.
- Defined:
  - Opcode 9 = MULH, returning the upper 32 bits of the unsigned 64-bit product.
  - It uses the same FSM and 32-cycle latency, with a 64-bit accumulator and multiplicand.
- Undefined:
  - Accumulator and multiplicand are 32 bits.
  - Opcode 9 is illegal: illegal_op pulses, no write.

Test Plan:
- Reset mid-op: assert reset asynchronously while applying a 32-cycle MUL -> result=0 and busy=0 immediately, no write_enable, start=0. ADD 5+7, dest 3, start 1 cycle -> next cycle write_enable=1, result=12, write_address=3, zero=0; following cycle write_enable=0.
- SUB 5−5 dest 4 -> result=0, zero=1. SUB 0−1 -> result=0xFFFFFFFF. SLT −1 vs 1 -> 1. SRL 0x80000000 by 31 -> 1.
- MUL 0x0000FFFF×0x00010001 dest 7 -> busy=1 for 32 cycles, then write_enable with result=0xFFFFFFFF and write_address=7. During the busy window, start an ADD -> ignored, no write.
- MUL 3×4 then ADD 1+1 started on the MUL write cycle -> write 12, then write 2 on the next cycle.
- Opcode 12 -> illegal_op pulses once, no write_enable. Opcode 9: with EXEC_MULH_EN, 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE after 32 cycles; without it, illegal_op.
